gray_ptr_decoder: RTL



---
 rtl/gray_pkg.sv | 39 +++
 rtl/gray_to_binary.sv | 18 +
 rtl/gray_ptr_decoder.sv | 123 ++++++++++++
 3 files changed

// File: rtl/gray_pkg.sv
// Shared Gray-code helpers for pointer-domain logic.
// Contents: pointer-tracking state enum, width-agnostic Gray<->binary
// conversions, and an all-ones mask helper.
package gray_pkg;

    // Widest pointer the helper functions handle.
    localparam int unsigned GRAY_MAX_W = 64;

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_TRACK = 2'd1,
        ST_ERROR = 2'd2
    } state_e;

    // Leading zeros decode to leading zeros, so a zero-extended word
    // converts correctly for any width up to GRAY_MAX_W.
    function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
        logic [GRAY_MAX_W-1:0] b;
        b = '0;
        b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
        for (int i = int'(GRAY_MAX_W) - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Mask with the low w bits set.
    function automatic logic [GRAY_MAX_W-1:0] all_ones(input int unsigned w);
        if (w >= GRAY_MAX_W) begin
            return '1;
        end
        return (GRAY_MAX_W'(1) << w) - GRAY_MAX_W'(1);
    endfunction

endpackage

// File: rtl/gray_to_binary.sv
// Combinational Gray-to-binary decoder, inverse of binary_to_gray.
// Ports:
//   gray_i  WIDTH  Gray-coded word
//   bin_o   WIDTH  binary equivalent
module gray_to_binary
    import gray_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] gray_i,
    output logic [WIDTH-1:0] bin_o
);

    always_comb begin
        bin_o = WIDTH'(gray2bin(GRAY_MAX_W'(gray_i)));
    end

endmodule

// File: rtl/gray_ptr_decoder.sv
// Decodes a stream of Gray-coded pointer samples, computes the modular step
// from the previous accepted sample and flags illegal jumps.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   resync        drop reference sample and clear sticky error
//   in_valid/in_ready/in_gray     input handshake and Gray sample
//   out_valid/out_ready           output handshake (single register stage)
//   out_bin, out_step, out_legal  decoded pointer, step, legality
//   err_sticky, err_cnt           illegal-step flag and saturating count
module gray_ptr_decoder
    import gray_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned BIDIR     = 0,
    parameter int unsigned ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 resync,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_gray,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_bin,
    output logic [WIDTH-1:0]     out_step,
    output logic                 out_legal,
    output logic                 err_sticky,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    localparam logic [WIDTH-1:0]     STEP_ONE = WIDTH'(1);
    localparam logic [WIDTH-1:0]     STEP_M1  = WIDTH'(all_ones(WIDTH));
    localparam logic [ERR_CNT_W-1:0] CNT_MAX  = ERR_CNT_W'(all_ones(ERR_CNT_W));

    state_e                 state_q;
    logic [WIDTH-1:0]       prev_gray_q;
    logic [WIDTH-1:0]       prev_bin_q;
    logic                   out_valid_q;
    logic [WIDTH-1:0]       out_bin_q;
    logic [WIDTH-1:0]       out_step_q;
    logic                   out_legal_q;
    logic                   err_sticky_q;
    logic [ERR_CNT_W-1:0]   err_cnt_q;

    logic [WIDTH-1:0]       bin_new;
    logic [WIDTH-1:0]       step_c;
    logic                   legal_c;
    logic                   accept;

    gray_to_binary #(
        .WIDTH (WIDTH)
    ) u_dec (
        .gray_i (in_gray),
        .bin_o  (bin_new)
    );

    // Ready is held high through reset so upstream never sees an X/stall there.
    assign in_ready = rst || !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    // Identical Gray words mean a zero step without waiting on the subtractor.
    always_comb begin
        step_c  = bin_new - prev_bin_q;
        legal_c = (in_gray == prev_gray_q) || (step_c == STEP_ONE) ||
                  ((BIDIR != 0) && (step_c == STEP_M1));
    end

    // Tracking FSM, reference sample, output register and error counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_INIT;
            prev_gray_q  <= '0;
            prev_bin_q   <= '0;
            out_valid_q  <= 1'b0;
            out_bin_q    <= '0;
            out_step_q   <= '0;
            out_legal_q  <= 1'b0;
            err_sticky_q <= 1'b0;
            err_cnt_q    <= '0;
        end else begin
            if (accept) begin
                out_valid_q <= 1'b1;
                out_bin_q   <= bin_new;
                prev_gray_q <= in_gray;
                prev_bin_q  <= bin_new;
                // A sample taken alongside resync becomes the new reference.
                if ((state_q == ST_INIT) || resync) begin
                    out_step_q  <= '0;
                    out_legal_q <= 1'b1;
                    state_q     <= ST_TRACK;
                end else begin
                    out_step_q  <= step_c;
                    out_legal_q <= legal_c;
                    if (!legal_c) begin
                        err_sticky_q <= 1'b1;
                        state_q      <= ST_ERROR;
                        if (err_cnt_q != CNT_MAX) begin
                            err_cnt_q <= err_cnt_q + ERR_CNT_W'(1);
                        end
                    end
                end
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
            end

            if (resync) begin
                err_sticky_q <= 1'b0;
                if (!accept) begin
                    state_q <= ST_INIT;
                end
            end
        end
    end

    assign out_valid  = out_valid_q;
    assign out_bin    = out_bin_q;
    assign out_step   = out_step_q;
    assign out_legal  = out_legal_q;
    assign err_sticky = err_sticky_q;
    assign err_cnt    = err_cnt_q;

endmodule
